// File: rtl/regfile_wb_ctrl_if.sv
// Writeback bus between the result producers (ALU, LSU) and the register file write port.
// The slave modport is the writeback controller; the master modport is the producers/consumer side.
interface regfile_wb_ctrl_if #(
  parameter int n       = 32,
  parameter int address = 5
);
  logic                    alu_valid_i;
  logic                    alu_ready_o;
  logic [address-1:0]      alu_addr_i;
  logic [n-1:0]            alu_data_i;
  logic                    lsu_valid_i;
  logic                    lsu_ready_o;
  logic [address-1:0]      lsu_addr_i;
  logic [n-1:0]            lsu_data_i;
  logic                    rd_wr_o;
  logic [address-1:0]      rd_addr_o;
  logic [n-1:0]            rd_data_o;
  logic [2**address-1:0]   pend_o;

  modport slave (
    input  alu_valid_i, alu_addr_i, alu_data_i,
    input  lsu_valid_i, lsu_addr_i, lsu_data_i,
    output alu_ready_o, lsu_ready_o,
    output rd_wr_o, rd_addr_o, rd_data_o, pend_o
  );

  modport master (
    output alu_valid_i, alu_addr_i, alu_data_i,
    output lsu_valid_i, lsu_addr_i, lsu_data_i,
    input  alu_ready_o, lsu_ready_o,
    input  rd_wr_o, rd_addr_o, rd_data_o, pend_o
  );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// Register file writeback controller: ALU priority, LSU results buffered in a FIFO, starvation guard.
// Optional macro REGFILE_WB_STAT_EN adds the stall_cnt_o stall statistics counter.
module regfile_wb_ctrl #(
  parameter int n       = 32,
  parameter int address = 5,
  parameter int DEPTH   = 4,
  parameter int STARVE  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
`ifdef REGFILE_WB_STAT_EN
  output logic [15:0]       stall_cnt_o,
  regfile_wb_ctrl_if.slave  bus
`else
  regfile_wb_ctrl_if.slave  bus
`endif
);
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int SW   = $clog2(STARVE) + 1;
  localparam int NREG = 2**address;

  typedef enum logic [1:0] {IDLE, COUNT, FORCE} state_t;

  state_t            state_reg, state_next;
  logic [SW-1:0]     starve_reg, starve_next;

  logic [address-1:0] fifo_addr [DEPTH];
  logic [n-1:0]       fifo_data [DEPTH];
  logic [PW-1:0]      rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]      count_reg;

  logic               rd_wr_reg;
  logic [address-1:0] rd_addr_reg;
  logic [n-1:0]       rd_data_reg;

  logic fifo_ne, alu_ready, lsu_ready, alu_win, pop, push, enq;

  assign fifo_ne   = count_reg != '0;
  assign lsu_ready = count_reg < CW'(DEPTH);
  assign alu_ready = state_reg != FORCE;
  assign alu_win   = bus.alu_valid_i & alu_ready & (bus.alu_addr_i != '0);
  assign pop       = ~alu_win & fifo_ne;
  assign push      = bus.lsu_valid_i & lsu_ready;
  // Loads to r0 complete the handshake but never occupy a slot.
  assign enq       = push & (bus.lsu_addr_i != '0);

  assign bus.alu_ready_o = alu_ready;
  assign bus.lsu_ready_o = lsu_ready;

  always_ff @(posedge clk_i) begin
    if (enq) begin
      fifo_addr[wr_ptr_reg] <= bus.lsu_addr_i;
      fifo_data[wr_ptr_reg] <= bus.lsu_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (enq) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CW'(enq) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg  <= IDLE;
      starve_reg <= '0;
    end else begin
      state_reg  <= state_next;
      starve_reg <= starve_next;
    end
  end

  // A forced cycle never has an ALU win, so it falls through to IDLE with the counter cleared.
  always_comb begin
    state_next  = IDLE;
    starve_next = '0;
    if (alu_win && fifo_ne) begin
      if (starve_reg == SW'(STARVE - 1)) begin
        state_next = FORCE;
      end else begin
        state_next  = COUNT;
        starve_next = starve_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_wr_reg   <= 1'b0;
      rd_addr_reg <= '0;
      rd_data_reg <= '0;
    end else begin
      rd_wr_reg <= alu_win | pop;
      if (alu_win) begin
        rd_addr_reg <= bus.alu_addr_i;
        rd_data_reg <= bus.alu_data_i;
      end else if (pop) begin
        rd_addr_reg <= fifo_addr[rd_ptr_reg];
        rd_data_reg <= fifo_data[rd_ptr_reg];
      end
    end
  end

  assign bus.rd_wr_o   = rd_wr_reg;
  assign bus.rd_addr_o = rd_addr_reg;
  assign bus.rd_data_o = rd_data_reg;

  // A slot is live when its distance from the read pointer is below the occupancy.
  logic [NREG-1:0] slot_mask [DEPTH];
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [PW-1:0] offset;
    assign offset        = PW'(gi) - rd_ptr_reg;
    assign slot_mask[gi] = ({1'b0, offset} < count_reg) ? (NREG'(1) << fifo_addr[gi]) : '0;
  end

  logic [NREG-1:0] pend;
  always_comb begin
    pend = '0;
    if (rd_wr_reg) pend[rd_addr_reg] = 1'b1;
    for (int i = 0; i < DEPTH; i++) pend = pend | slot_mask[i];
    pend[0] = 1'b0;
  end
  assign bus.pend_o = pend;

`ifdef REGFILE_WB_STAT_EN
  logic [15:0] stall_reg;
  logic [16:0] stall_sum;
  assign stall_sum = {1'b0, stall_reg}
                   + 17'(bus.lsu_valid_i & ~lsu_ready)
                   + 17'(bus.alu_valid_i & ~alu_ready);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) stall_reg <= '0;
    else        stall_reg <= stall_sum[16] ? 16'hFFFF : stall_sum[15:0];
  end
  assign stall_cnt_o = stall_reg;
`endif
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: directed scenarios plus random traffic against a queue model.
module tb_regfile_wb_ctrl;
  localparam int N      = 32;
  localparam int A      = 5;
  localparam int DEPTH  = 4;
  localparam int STARVE = 8;
  localparam int NREG   = 2**A;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  regfile_wb_ctrl_if #(.n(N), .address(A)) bus ();

`ifdef REGFILE_WB_STAT_EN
  logic [15:0] stall_cnt;
  regfile_wb_ctrl #(.n(N), .address(A), .DEPTH(DEPTH), .STARVE(STARVE)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_cnt_o(stall_cnt), .bus(bus));
`else
  regfile_wb_ctrl #(.n(N), .address(A), .DEPTH(DEPTH), .STARVE(STARVE)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus));
`endif

  typedef struct packed {
    logic [A-1:0] addr;
    logic [N-1:0] data;
  } ent_t;

  ent_t         m_q[$];
  int           m_wins;
  bit           m_force;
  logic         e_wr;
  logic [A-1:0] e_addr;
  logic [N-1:0] e_data;
  int           m_stall;
  int           checks = 0;
  int           errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREG-1:0] exp_pend();
    logic [NREG-1:0] p;
    p = '0;
    foreach (m_q[i]) p[m_q[i].addr] = 1'b1;
    if (e_wr) p[e_addr] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_wins  = 0;
    m_force = 1'b0;
    e_wr    = 1'b0;
    e_addr  = '0;
    e_data  = '0;
    m_stall = 0;
  endtask

  task automatic drive_idle();
    bus.alu_valid_i = 1'b0;
    bus.alu_addr_i  = '0;
    bus.alu_data_i  = '0;
    bus.lsu_valid_i = 1'b0;
    bus.lsu_addr_i  = '0;
    bus.lsu_data_i  = '0;
  endtask

  // One clock of stimulus; the model decides grants from the rules, then outputs are checked.
  task automatic cycle(input bit av, input logic [A-1:0] aa, input logic [N-1:0] ad,
                       input bit lv, input logic [A-1:0] la, input logic [N-1:0] ld,
                       output bit lsu_acc);
    bit   lrdy, ardy, win, waiting;
    int   inc;
    ent_t h;
    @(negedge clk_i);
    bus.alu_valid_i = av; bus.alu_addr_i = aa; bus.alu_data_i = ad;
    bus.lsu_valid_i = lv; bus.lsu_addr_i = la; bus.lsu_data_i = ld;
    #1;
    lrdy = m_q.size() < DEPTH;
    ardy = !m_force;
    check("lsu_ready", bus.lsu_ready_o, lrdy);
    check("alu_ready", bus.alu_ready_o, ardy);
    inc = ((lv && !lrdy) ? 1 : 0) + ((av && !ardy) ? 1 : 0);
    m_stall = (m_stall + inc > 65535) ? 65535 : m_stall + inc;
    win     = av && ardy && (aa != 0);
    waiting = m_q.size() != 0;
    if (win) begin
      e_wr = 1'b1; e_addr = aa; e_data = ad;
    end else if (waiting) begin
      h = m_q.pop_front();
      e_wr = 1'b1; e_addr = h.addr; e_data = h.data;
    end else begin
      e_wr = 1'b0;
    end
    // Starvation rule: the STARVE-th consecutive ALU win over waiting LSU data forces a pop next.
    if (m_force) begin
      m_force = 1'b0;
      m_wins  = 0;
    end else if (win && waiting) begin
      m_wins++;
      if (m_wins == STARVE) begin
        m_force = 1'b1;
        m_wins  = 0;
      end
    end else begin
      m_wins = 0;
    end
    lsu_acc = lv && lrdy;
    if (lsu_acc && la != 0) m_q.push_back({la, ld});
    @(posedge clk_i);
    #1;
    check("rd_wr", bus.rd_wr_o, e_wr);
    check("rd_addr", bus.rd_addr_o, e_addr);
    check("rd_data", bus.rd_data_o, e_data);
    check("pend", bus.pend_o, exp_pend());
`ifdef REGFILE_WB_STAT_EN
    check("stall_cnt", stall_cnt, m_stall);
`endif
  endtask

  initial begin
    bit acc;
    int pushed;
    model_reset();
    drive_idle();

    // Reset held with random inputs
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      bus.alu_valid_i = 1'($urandom); bus.alu_addr_i = A'($urandom); bus.alu_data_i = $urandom;
      bus.lsu_valid_i = 1'($urandom); bus.lsu_addr_i = A'($urandom); bus.lsu_data_i = $urandom;
      #1;
      check("rst_lsu_ready", bus.lsu_ready_o, 1'b1);
      check("rst_alu_ready", bus.alu_ready_o, 1'b1);
      check("rst_rd_wr", bus.rd_wr_o, 1'b0);
      check("rst_pend", bus.pend_o, '0);
`ifdef REGFILE_WB_STAT_EN
      check("rst_stall", stall_cnt, 16'h0);
`endif
    end
    drive_idle();
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int c = 0; c < 3; c++) cycle(0, '0, '0, 0, '0, '0, acc);

    // ALU only, then idle, then ALU to r0
    cycle(1, 5'd5, 32'hDEADBEEF, 0, '0, '0, acc);
    check("alu5_wr", bus.rd_wr_o, 1'b1);
    check("alu5_data", bus.rd_data_o, 32'hDEADBEEF);
    check("alu5_pend", bus.pend_o[5], 1'b1);
    cycle(0, '0, '0, 0, '0, '0, acc);
    cycle(1, 5'd0, 32'h12345678, 0, '0, '0, acc);
    check("alu0_wr", bus.rd_wr_o, 1'b0);

    // Five LSU pushes while the ALU writes r9 every cycle; exercises full FIFO and the starvation guard
    pushed = 0;
    for (int c = 0; c < 30 && pushed < 5; c++) begin
      cycle(1, 5'd9, $urandom, 1, A'(pushed + 1), $urandom, acc);
      if (acc) pushed++;
    end
    check("queue_pushes", pushed, 5);
    for (int c = 0; c < 3; c++) cycle(1, 5'd9, $urandom, 0, '0, '0, acc);
    for (int c = 0; c < 6; c++) cycle(0, '0, '0, 0, '0, '0, acc);

    // Build three entries behind the ALU, then push and pop together with the ALU idle
    for (int c = 1; c <= 3; c++) cycle(1, 5'd7, $urandom, 1, A'(c), $urandom, acc);
    cycle(0, '0, '0, 1, 5'd4, $urandom, acc);
    check("pushpop_acc", acc, 1'b1);
    for (int c = 0; c < 5; c++) cycle(0, '0, '0, 0, '0, '0, acc);

    // Random traffic
    for (int c = 0; c < 300; c++) begin
      cycle(($urandom_range(0, 3) != 0), A'($urandom_range(0, 31)), $urandom,
            ($urandom_range(0, 2) != 0), A'($urandom_range(0, 31)), $urandom, acc);
    end
    for (int c = 0; c < 8; c++) cycle(0, '0, '0, 0, '0, '0, acc);

    // Reset mid-drain with entries queued and a write in flight
    for (int c = 1; c <= 3; c++) cycle(1, 5'd11, $urandom, 1, A'(c + 20), $urandom, acc);
    cycle(0, '0, '0, 0, '0, '0, acc);
    #2;
    rst_i = 1'b0;
    #1;
    check("midrst_rd_wr", bus.rd_wr_o, 1'b0);
    check("midrst_pend", bus.pend_o, '0);
    model_reset();
    drive_idle();
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int c = 0; c < 4; c++) cycle(0, '0, '0, 0, '0, '0, acc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
Writeback controller that drives the write port of the register file (the writer end of that interface).
- Merges two result producers onto the single write port: the ALU (single-cycle, priority) and the LSU (variable latency, buffered in a small FIFO).
- Produces registered rd_wr/rd_addr/rd_data for the register file.
- Exports a per-register pending mask that decode uses for RAW hazard checks.

Parameters:
n, 32, data width
address, 5, register address width; pending mask width is 2**address
DEPTH, 4, LSU result FIFO depth (power of 2, >=2)
STARVE, 8, max consecutive cycles ALU may win the port while the FIFO is non-empty

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset; asynchronous and active-low
alu_valid_i  input  1  ALU result valid
alu_ready_o  output  1  ALU result accepted this cycle
alu_addr_i  input  address  ALU destination register
alu_data_i  input  n  ALU result
lsu_valid_i  input  1  LSU result valid
lsu_ready_o  output  1  LSU result accepted this cycle
lsu_addr_i  input  address  LSU destination register
lsu_data_i  input  n  LSU load data
rd_wr_o  output  1  register file write enable
rd_addr_o  output  address  register file write address
rd_data_o  output  n  register file write data
pend_o  output  2**address  bit k=1: a write to register k is queued or in the output stage

Behaviour:
- Reset (rst_i=0, async): rd_wr_o=0, rd_addr_o=0, rd_data_o=0, FIFO empty, starve counter=0, force flag=0. Resulting combinational outputs: lsu_ready_o=1, alu_ready_o=1, pend_o=0.
- Reset mid-operation: all queued entries and any in-flight output-stage write are discarded; no write reaches the register file.
- LSU side:
  - lsu_ready_o = (count < DEPTH), from state only; no dependence on a same-cycle pop.
  - Push on lsu_valid_i & lsu_ready_o.
  - lsu_addr_i==0: handshake completes but nothing is enqueued.
  - Push and pop in the same cycle are allowed whenever not full; count is unchanged.
- ALU side:
  - alu_ready_o = ~force flag (combinational from state).
  - ALU result with alu_addr_i==0 is accepted and dropped.
- Port select each cycle, in priority order:
  1. alu_valid_i & alu_ready_o & alu_addr_i!=0: write ALU result.
  2. Else if FIFO non-empty: pop head and write it.
  3. Else: rd_wr_o=0 next cycle.
- Output stage:
  - Registered, so rd_wr_o/rd_addr_o/rd_data_o update one cycle after selection.
  - When idle, rd_addr_o and rd_data_o hold their previous values.
- Latency:
  - ALU: 1 cycle, accept to rd_wr_o.
  - LSU: minimum 2 cycles, push to rd_wr_o (push cycle, then pop cycle); there is no FIFO bypass.
- Starvation guard (state machine IDLE/COUNT/FORCE):
  - Counter increments each cycle the ALU wins while the FIFO is non-empty.
  - Counter clears on any FIFO pop, or when the FIFO is empty.
  - When counter reaches STARVE-1 and the ALU wins again, force flag sets for exactly one cycle. In that cycle alu_ready_o=0 and the FIFO head pops.
  - Force flag then clears and the counter resets to 0.
- pend_o:
  - Bit k is set if any valid FIFO entry has addr k, or rd_wr_o=1 with rd_addr_o=k.
  - Combinational from state; bit 0 is always 0.
- FIFO pointers are address-wrapping modulo DEPTH; count has width clog2(DEPTH)+1.
- Ordering:
  - LSU results are written in push order.
  - ALU/LSU results to the same register are written in port-grant order; upstream guarantees no WAW between units.

Optional Feature:
Macro REGFILE_WB_STAT_EN adds output stall_cnt_o, 16 bits, reset 0.
- It counts cycles with lsu_valid_i=1 & lsu_ready_o=0, plus cycles with alu_valid_i=1 & alu_ready_o=0.
- When both conditions hold in the same cycle, it adds 2.
- The counter saturates at 16'hFFFF.
Without the macro, the port and counter do not exist and all other behaviour is identical.

Test Plan:
- Reset then idle: hold rst_i=0 with random inputs → rd_wr_o=0, pend_o=0, lsu_ready_o=1, alu_ready_o=1. Release reset, no valids → rd_wr_o stays 0.
- ALU only: alu_valid_i=1, addr=5, data=32'hDEADBEEF for 1 cycle → next cycle rd_wr_o=1, rd_addr_o=5, rd_data_o=32'hDEADBEEF, pend_o[5]=1. Following cycle rd_wr_o=0. ALU addr=0 → no write.
- LSU queueing: push 5 LSU results (addrs 1..5) back-to-back with the ALU writing every cycle (addr 9) → lsu_ready_o=0 after 4 pushes; pend_o[1..4]=1.
- Starvation (same setup as queueing, STARVE=8): after 8 ALU wins, alu_ready_o=0 for one cycle and addr 1 is written. The 5th push completes on the next cycle.
- Simultaneous push/pop at count=3, ALU idle: count stays 3, lsu_ready_o stays 1. Entries drain in order 1,2,3,4, one per cycle, with data matching.
- Reset mid-drain: assert rst_i=0 with 3 entries queued → rd_wr_o=0 immediately (async), pend_o=0. After release no stale writes; with REGFILE_WB_STAT_EN, stall_cnt_o=0.
